camera_capture_sequencer: RTL and testbench

Sequences single-frame captures for the camera pipeline, sitting between the SPI register block and the image datapath. It takes the capture-request pulse and aligns it to sensor frame boundaries, so exactly one whole frame is captured. While that frame is captured it gates the compressed-byte stream into the frame buffer, and it publishes the byte count and status back to the SPI register block.

---
 rtl/camera_capture_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_camera_capture_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture_sequencer.sv
// camera_capture_sequencer
//
// This block sequences a single-frame capture between the SPI register block
// and the image datapath. A one-cycle capture request is aligned to sensor
// frame boundaries so that exactly one whole frame is captured. While that
// frame is live, the block gates the compressed-byte stream into the frame
// buffer. When the frame ends, it reports the byte count and status back to
// the register block.
//
// Optional feature: define CAPTURE_TIMEOUT_EN to give up waiting for frame
// start after TIMEOUT_CYCLES clocks. Without it the block waits indefinitely
// and timeout_out is tied low.
//
// Parameters:
//   BUFFER_BYTES        frame buffer capacity in bytes (1..65535)
//   TIMEOUT_CYCLES      clocks allowed from arming until frame start
//
// Ports:
//   clock_in            single clock
//   reset_in            synchronous, active-high reset
//   start_capture_in    one-cycle capture request
//   frame_valid_in      sensor frame-active level (already synchronous)
//   byte_valid_in       compressed pipeline has a byte this cycle
//   capture_enable_out  high for exactly the captured frame
//   write_enable_out    frame-buffer write strobe
//   write_address_out   frame-buffer byte address
//   bytes_available_out bytes written in the current/last capture
//   busy_out            high while arming, waiting or capturing
//   done_out            one-cycle pulse when a capture completes
//   metering_latch_out  one-cycle pulse alongside a normal completion
//   overflow_out        sticky: frame exceeded the buffer
//   timeout_out         sticky: frame start did not arrive in time
module camera_capture_sequencer #(
    parameter int unsigned BUFFER_BYTES   = 16384,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        start_capture_in,
    input  logic        frame_valid_in,
    input  logic        byte_valid_in,
    output logic        capture_enable_out,
    output logic        write_enable_out,
    output logic [15:0] write_address_out,
    output logic [15:0] bytes_available_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        metering_latch_out,
    output logic        overflow_out,
    output logic        timeout_out
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_START,
        CAPTURING,
        DONE
    } state_t;

    localparam logic [15:0] BUF_LIMIT = 16'(BUFFER_BYTES);

    state_t      state;
    state_t      state_next;
    logic        fv_q;
    logic        rise;
    logic        fall;
    logic [15:0] count;
    logic        overflow_q;
    logic        timeout_q;
    logic        done_q;
    logic        meter_q;
    logic        start_ok;
    logic        accept;
    logic        overrun;
    logic        capture_end;
    logic        timeout_hit;

    assign rise = frame_valid_in & ~fv_q;
    assign fall = ~frame_valid_in & fv_q;

    // A start that coincides with the completion pulse is dropped, so the
    // register block cannot re-arm in the same cycle it observes completion.
    assign start_ok    = start_capture_in &&
                         ((state == IDLE) || ((state == DONE) && !done_q));
    assign accept      = (state == CAPTURING) && byte_valid_in && (count < BUF_LIMIT);
    assign overrun     = (state == CAPTURING) && byte_valid_in && (count == BUF_LIMIT);
    assign capture_end = (state == CAPTURING) && fall;

`ifdef CAPTURE_TIMEOUT_EN
    logic [23:0] wait_count;

    // A rising edge on the very last allowed cycle still wins over the timeout.
    assign timeout_hit = (wait_count == (TIMEOUT_CYCLES - 24'd1)) &&
                         ((state == ARM) || ((state == WAIT_START) && !rise));

    // The wait counter measures the whole arm/wait phase from the accepted
    // start, so it is cleared only when a new capture is armed.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wait_count <= 24'd0;
        end else if (start_ok) begin
            wait_count <= 24'd0;
        end else if ((state == ARM) || (state == WAIT_START)) begin
            wait_count <= wait_count + 24'd1;
        end
    end
`else
    logic unused_timeout_cycles;

    assign timeout_hit           = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // State register.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    // Starting mid-frame arms first so a partial frame is skipped.
                    state_next = frame_valid_in ? ARM : WAIT_START;
                end
            end
            ARM: begin
                if (timeout_hit) begin
                    state_next = DONE;
                end else if (fall) begin
                    state_next = WAIT_START;
                end
            end
            WAIT_START: begin
                if (timeout_hit) begin
                    state_next = DONE;
                end else if (rise) begin
                    state_next = CAPTURING;
                end
            end
            CAPTURING: begin
                if (fall) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. These hold the frame-valid history, the byte count,
    // the sticky status flags and the one-cycle completion pulses.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            fv_q       <= 1'b0;
            count      <= 16'd0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            meter_q    <= 1'b0;
        end else begin
            fv_q    <= frame_valid_in;
            done_q  <= capture_end || timeout_hit;
            meter_q <= capture_end;
            if (start_ok) begin
                count      <= 16'd0;
                overflow_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                if (accept) begin
                    count <= count + 16'd1;
                end
                if (overrun) begin
                    overflow_q <= 1'b1;
                end
                if (timeout_hit) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    // Output logic. The write strobe and address have zero latency from
    // byte_valid_in, so the buffer sees each byte in the cycle it arrives.
    always_comb begin
        capture_enable_out  = (state == CAPTURING);
        busy_out            = (state == ARM) || (state == WAIT_START) || (state == CAPTURING);
        write_enable_out    = accept;
        write_address_out   = count;
        bytes_available_out = count;
        done_out            = done_q;
        metering_latch_out  = meter_q;
        overflow_out        = overflow_q;
        timeout_out         = timeout_q;
    end

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// tb_camera_capture_sequencer
//
// This is a directed testbench for camera_capture_sequencer.
//
// Two instances share the same stimulus. The first uses the default buffer
// size. The second uses a 16-byte buffer and a 100-cycle timeout, which makes
// the overflow and timeout behaviour reachable in a short run. A monitor
// watches whichever instance is selected.
//
// Expected write addresses are queued as bytes are driven. The monitor pops
// and compares an entry each time it sees a write strobe.
module tb_camera_capture_sequencer;

    logic        clock = 1'b0;
    logic        resetIn = 1'b1;
    logic        startIn = 1'b0;
    logic        fvIn = 1'b0;
    logic        bvIn = 1'b0;

    logic        ceD, weD, busyD, doneD, meterD, ovfD, toD;
    logic [15:0] addrD, availD;
    logic        ceS, weS, busyS, doneS, meterS, ovfS, toS;
    logic [15:0] addrS, availS;

    bit          monSmall = 1'b0;
    logic        monCe, monWe, monBusy, monDone, monMeter, monOvf, monTo;
    logic [15:0] monAddr, monAvail;

    int          tests = 0;
    int          failures = 0;
    int          ceCycles = 0;
    int          doneCount = 0;
    int          meterCount = 0;
    int          ceBase, doneBase, meterBase;
    int          nextAddr = 0;
    int          byteNum;
    logic [15:0] expQ[$];

    always #5 clock = ~clock;

    camera_capture_sequencer dut (
        .clock_in            (clock),
        .reset_in            (resetIn),
        .start_capture_in    (startIn),
        .frame_valid_in      (fvIn),
        .byte_valid_in       (bvIn),
        .capture_enable_out  (ceD),
        .write_enable_out    (weD),
        .write_address_out   (addrD),
        .bytes_available_out (availD),
        .busy_out            (busyD),
        .done_out            (doneD),
        .metering_latch_out  (meterD),
        .overflow_out        (ovfD),
        .timeout_out         (toD)
    );

    camera_capture_sequencer #(
        .BUFFER_BYTES   (16),
        .TIMEOUT_CYCLES (24'd100)
    ) dutSmall (
        .clock_in            (clock),
        .reset_in            (resetIn),
        .start_capture_in    (startIn),
        .frame_valid_in      (fvIn),
        .byte_valid_in       (bvIn),
        .capture_enable_out  (ceS),
        .write_enable_out    (weS),
        .write_address_out   (addrS),
        .bytes_available_out (availS),
        .busy_out            (busyS),
        .done_out            (doneS),
        .metering_latch_out  (meterS),
        .overflow_out        (ovfS),
        .timeout_out         (toS)
    );

    // Select which instance the monitor and checks look at.
    always_comb begin
        monCe    = monSmall ? ceS    : ceD;
        monWe    = monSmall ? weS    : weD;
        monBusy  = monSmall ? busyS  : busyD;
        monDone  = monSmall ? doneS  : doneD;
        monMeter = monSmall ? meterS : meterD;
        monOvf   = monSmall ? ovfS   : ovfD;
        monTo    = monSmall ? toS    : toD;
        monAddr  = monSmall ? addrS  : addrD;
        monAvail = monSmall ? availS : availD;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // The monitor samples at the falling edge, mid-cycle. It counts the
    // completion pulses and checks every write against the scoreboard.
    always @(negedge clock) begin
        if (monCe) ceCycles++;
        if (monDone) doneCount++;
        if (monMeter) meterCount++;
        if (monWe) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 32'(monWe), 32'd0);
            end else begin
                checkOutput("write_address", 32'(monAddr), 32'(expQ.pop_front()));
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge. Return after the
    // monitor has sampled that cycle's outputs.
    task automatic applyStimulus(input logic rst, input logic start,
                                 input logic fv, input logic bv);
        @(posedge clock);
        #1;
        resetIn = rst;
        startIn = start;
        fvIn    = fv;
        bvIn    = bv;
        @(negedge clock);
        #1;
    endtask

    task automatic pushByte();
        expQ.push_back(16'(nextAddr));
        nextAddr++;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expQ.delete();
        nextAddr = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_flags"},
                    32'({monCe, monWe, monBusy, monDone, monMeter, monOvf, monTo}), 32'd0);
        checkOutput({tag, "_avail"}, 32'(monAvail), 32'd0);
        checkOutput({tag, "_addr"}, 32'(monAddr), 32'd0);
    endtask

    task automatic snapshot();
        ceBase    = ceCycles;
        doneBase  = doneCount;
        meterBase = meterCount;
    endtask

    initial begin
        // Reset state.
        doReset();
        checkAllZero("reset");

        // Basic capture: a 100-cycle frame with a byte every other cycle.
        monSmall = 1'b0;
        snapshot();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("basic_busy_start_cycle", 32'(monBusy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_busy_armed", 32'(monBusy), 32'd1);
        checkOutput("basic_ce_before_frame", 32'(monCe), 32'd0);
        for (int c = 0; c < 100; c++) begin
            if (c % 2 == 1) pushByte();
            applyStimulus(1'b0, 1'b0, 1'b1, (c % 2 == 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_ce_fall_cycle", 32'(monCe), 32'd1);
        checkOutput("basic_done_fall_cycle", 32'(monDone), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_done", 32'(monDone), 32'd1);
        checkOutput("basic_meter", 32'(monMeter), 32'd1);
        checkOutput("basic_ce_off", 32'(monCe), 32'd0);
        checkOutput("basic_busy_off", 32'(monBusy), 32'd0);
        checkOutput("basic_avail", 32'(monAvail), 32'd50);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_ce_cycles", 32'(ceCycles - ceBase), 32'd100);
        checkOutput("basic_done_count", 32'(doneCount - doneBase), 32'd1);
        checkOutput("basic_meter_count", 32'(meterCount - meterBase), 32'd1);
        checkOutput("basic_queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("basic_avail_hold", 32'(monAvail), 32'd50);

        // Mid-frame start: the partial frame's 30 bytes must not be written.
        doReset();
        snapshot();
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 60; c++) applyStimulus(1'b0, 1'b0, 1'b1, (c % 2 == 1));
        checkOutput("mid_busy_armed", 32'(monBusy), 32'd1);
        checkOutput("mid_ce_partial", 32'(monCe), 32'd0);
        checkOutput("mid_avail_partial", 32'(monAvail), 32'd0);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 80; c++) begin
            if (c % 2 == 1) pushByte();
            applyStimulus(1'b0, 1'b0, 1'b1, (c % 2 == 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_done", 32'(monDone), 32'd1);
        checkOutput("mid_avail", 32'(monAvail), 32'd40);
        checkOutput("mid_queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("mid_done_count", 32'(doneCount - doneBase), 32'd1);

        // Overflow on the 16-byte instance: 20 bytes offered, 16 written.
        doReset();
        monSmall = 1'b1;
        snapshot();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        byteNum = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 1) begin
                if (byteNum < 16) pushByte();
                byteNum++;
            end
            applyStimulus(1'b0, 1'b0, 1'b1, (c % 2 == 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_done", 32'(monDone), 32'd1);
        checkOutput("ovf_flag", 32'(monOvf), 32'd1);
        checkOutput("ovf_avail", 32'(monAvail), 32'd16);
        checkOutput("ovf_queue_drained", 32'(expQ.size()), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_cleared", 32'(monOvf), 32'd0);
        checkOutput("ovf_avail_cleared", 32'(monAvail), 32'd0);
        checkOutput("ovf_rearmed_busy", 32'(monBusy), 32'd1);

        // Ignored starts: one during capture and one in the done cycle.
        doReset();
        monSmall = 1'b0;
        snapshot();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 1) pushByte();
            applyStimulus(1'b0, (c == 10), 1'b1, (c % 2 == 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ign_done", 32'(monDone), 32'd1);
        checkOutput("ign_avail", 32'(monAvail), 32'd10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ign_not_rearmed", 32'(monBusy), 32'd0);
        checkOutput("ign_avail_hold", 32'(monAvail), 32'd10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ign_done_count", 32'(doneCount - doneBase), 32'd1);
        checkOutput("ign_queue_drained", 32'(expQ.size()), 32'd0);

        // Reset during capture after 5 bytes.
        doReset();
        snapshot();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 1) pushByte();
            applyStimulus(1'b0, 1'b0, 1'b1, (c % 2 == 1));
        end
        checkOutput("rst_avail_before", 32'(monAvail), 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAllZero("rst_mid");
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_no_done", 32'(doneCount - doneBase), 32'd0);
        checkOutput("rst_queue_drained", 32'(expQ.size()), 32'd0);

`ifdef CAPTURE_TIMEOUT_EN
        // Timeout on the 100-cycle instance. There are 100 full cycles of
        // waiting after the start cycle, and the flag appears the cycle after.
        doReset();
        monSmall = 1'b1;
        snapshot();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 100; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_not_yet", 32'(monTo), 32'd0);
        checkOutput("to_busy_waiting", 32'(monBusy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_flag", 32'(monTo), 32'd1);
        checkOutput("to_done", 32'(monDone), 32'd1);
        checkOutput("to_meter", 32'(monMeter), 32'd0);
        checkOutput("to_avail", 32'(monAvail), 32'd0);
        checkOutput("to_busy_off", 32'(monBusy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
